mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_arb_pick.sv | 18 +
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared defines: FSM state and
// transaction owner encodings.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational IF/LSU grant select.
// in: if_valid, ls_valid, last_grant; out: grant_if, grant_ls.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   if_valid,
  input  logic   ls_valid,
  input  owner_e last_grant,
  output logic   grant_if,
  output logic   grant_ls
);

  // On a tie the LSU wins unless it was granted last.
  assign grant_ls = ls_valid &
                    (!if_valid || last_grant == OWN_IF);
  assign grant_if = if_valid & !grant_ls;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: IF/LSU -> single memory port, one txn outstanding.
// Ports: if_*/ls_* requesters, mem_* memory, busy. Macro ARB_RR_EN = round-robin.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_valid,
  output logic              ls_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_wen,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [7:0]        ls_wmask,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wmask_q, wmask_d;
  owner_e            last_grant;
  logic              grant_if, grant_ls;
  logic              done;

  arb_pick u_pick (
    .if_valid   (if_valid),
    .ls_valid   (ls_valid),
    .last_grant (last_grant),
    .grant_if   (grant_if),
    .grant_ls   (grant_ls)
  );

`ifdef ARB_RR_EN
  owner_e last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= OWN_IF;
    end else if (if_ready || ls_ready) begin
      last_q <= ls_ready ? OWN_LS : OWN_IF;
    end
  end

  assign last_grant = last_q;
`else
  // Fixed priority: a constant IF "last grant" makes LSU win ties.
  assign last_grant = OWN_IF;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    if_ready  = 1'b0;
    ls_ready  = 1'b0;
    mem_valid = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // rst gate keeps ready low while reset is held.
        if (rst && (grant_if || grant_ls)) begin
          if_ready = grant_if;
          ls_ready = grant_ls;
          owner_d  = grant_ls ? OWN_LS : OWN_IF;
          addr_d   = grant_ls ? ls_addr : if_addr;
          wen_d    = grant_ls & ls_wen;
          wdata_d  = grant_ls ? ls_wdata : '0;
          wmask_d  = (grant_ls && ls_wen) ? ls_wmask : '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          if (mem_rvalid) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (mem_rvalid) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign if_rvalid = done && owner_q == OWN_IF;
  assign ls_rvalid = done && owner_q == OWN_LS;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

  assign mem_addr  = mem_valid ? addr_q  : '0;
  assign mem_wen   = mem_valid & wen_q;
  assign mem_wdata = mem_valid ? wdata_q : '0;
  assign mem_wmask = mem_valid ? wmask_q : '0;

  assign busy = state_q != S_IDLE;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + random checks of mem_arbiter
// against a transaction-level reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 0, ls_valid = 0;
  logic [63:0] if_addr = 0, ls_addr = 0;
  logic        ls_wen = 0;
  logic [63:0] ls_wdata = 0;
  logic [7:0]  ls_wmask = 0;
  logic        mem_ready = 0, mem_rvalid = 0;
  logic [63:0] mem_rdata = 0;
  logic        if_ready, if_rvalid, ls_ready, ls_rvalid;
  logic [63:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic        mem_valid, mem_wen, busy;
  logic [7:0]  mem_wmask;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_addr(if_addr), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .ls_valid(ls_valid), .ls_ready(ls_ready),
    .ls_addr(ls_addr), .ls_wen(ls_wen),
    .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: one pending transaction record.
  bit          m_busy, m_acked, m_own_ls, m_last_ls;
  logic [63:0] m_addr, m_wdata;
  bit          m_wen;
  logic [7:0]  m_wmask;

  task automatic m_reset();
    m_busy = 0; m_acked = 0; m_own_ls = 0;
    m_last_ls = 0; m_addr = 0; m_wdata = 0;
    m_wen = 0; m_wmask = 0;
  endtask

  task automatic pick(output bit gi, output bit gl);
    gi = 0;
    gl = 0;
    if (!m_busy && rst) begin
      if (if_valid && ls_valid) begin
`ifdef ARB_RR_EN
        gl = !m_last_ls;
        gi = m_last_ls;
`else
        gl = 1;
`endif
      end else begin
        gi = if_valid;
        gl = ls_valid;
      end
    end
  endtask

  function automatic bit m_done();
    return m_busy && mem_rvalid && (m_acked || mem_ready);
  endfunction

  function automatic logic outs_or();
    return |{if_ready, if_rvalid, if_rdata, ls_ready,
             ls_rvalid, ls_rdata, mem_valid, mem_addr,
             mem_wen, mem_wdata, mem_wmask, busy};
  endfunction

  task automatic check_model();
    bit gi, gl, dn, mv;
    pick(gi, gl);
    dn = m_done();
    mv = m_busy && !m_acked;
    chk("if_ready", if_ready, gi);
    chk("ls_ready", ls_ready, gl);
    chk("busy", busy, m_busy);
    chk("mem_valid", mem_valid, mv);
    chk("mem_addr", mem_addr, mv ? m_addr : 0);
    chk("mem_wen", mem_wen, mv && m_wen);
    chk("mem_wdata", mem_wdata, mv ? m_wdata : 0);
    chk("mem_wmask", mem_wmask, mv ? m_wmask : 0);
    chk("if_rvalid", if_rvalid, dn && !m_own_ls);
    chk("ls_rvalid", ls_rvalid, dn && m_own_ls);
    chk("if_rdata", if_rdata,
        (dn && !m_own_ls) ? mem_rdata : 0);
    chk("ls_rdata", ls_rdata,
        (dn && m_own_ls) ? mem_rdata : 0);
  endtask

  task automatic m_update();
    bit gi, gl;
    pick(gi, gl);
    if (!rst) begin
      m_reset();
    end else if (!m_busy) begin
      if (gi || gl) begin
        m_own_ls  = gl;
        m_addr    = gl ? ls_addr : if_addr;
        m_wen     = gl && ls_wen;
        m_wdata   = gl ? ls_wdata : 0;
        m_wmask   = (gl && ls_wen) ? ls_wmask : 0;
        m_busy    = 1;
        m_acked   = 0;
        m_last_ls = gl;
      end
    end else if (m_done()) begin
      m_busy = 0;
    end else if (!m_acked && mem_ready) begin
      m_acked = 1;
    end
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic cyc();
    #1 check_model();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle_in();
    if_valid = 0; ls_valid = 0; ls_wen = 0;
    mem_ready = 0; mem_rvalid = 0;
  endtask

  initial begin
    m_reset();
    if_valid = 1;
    ls_valid = 1;
    #2 chk("rst_outs", outs_or(), 0);
    cyc();
    cyc();
    idle_in();
    rst = 1;
    cyc();

    // IF-only fetch
    if_valid = 1; if_addr = 64'h8000_0000;
    #1 chk("t1_if_ready", if_ready, 1);
    cyc();
    if_valid = 0; mem_ready = 1;
    #1 chk("t1_mem_addr", mem_addr, 64'h8000_0000);
    cyc();
    mem_ready = 0;
    #1 chk("t1_no_rvalid", if_rvalid, 0);
    cyc();
    mem_rvalid = 1; mem_rdata = 64'h0010_0073;
    #1 chk("t1_rdata", if_rdata, 64'h0010_0073);
    cyc();
    mem_rvalid = 0;
    #1 chk("t1_idle", busy, 0);
    cyc();

    // simultaneous requests
    if_valid = 1; ls_valid = 1;
    ls_addr = 64'h8000_1000; ls_wen = 0;
    #1 chk("sim1_ls_ready", ls_ready, 1);
    cyc();
    ls_valid = 0; mem_ready = 1; mem_rvalid = 1;
    #1 chk("sim1_busy_if_ready", if_ready, 0);
    cyc();
    mem_ready = 0; mem_rvalid = 0;
    #1 chk("sim2_if_ready", if_ready, 1);
    cyc();
    if_valid = 0; mem_ready = 1; mem_rvalid = 1;
    cyc();
    if_valid = 1; ls_valid = 1;
    mem_ready = 0; mem_rvalid = 0;
    #1 chk("sim3_ls_ready", ls_ready, 1);
    cyc();
    mem_ready = 1; mem_rvalid = 1;
    cyc();
    mem_ready = 0; mem_rvalid = 0;
    cyc();
    idle_in();
    mem_ready = 1; mem_rvalid = 1;
    cyc();
    idle_in();
    cyc();

    // store held until mem_ready
    ls_valid = 1; ls_wen = 1; ls_wmask = 8'h0F;
    ls_wdata = 64'hDEAD_BEEF; ls_addr = 64'h100;
    cyc();
    idle_in();
    #1 chk("st_wmask", mem_wmask, 8'h0F);
    chk("st_wen", mem_wen, 1);
    cyc();
    #1 chk("st_wdata_hold", mem_wdata, 64'hDEAD_BEEF);
    cyc();
    mem_ready = 1;
    cyc();
    mem_ready = 0; mem_rvalid = 1;
    #1 chk("st_ack", ls_rvalid, 1);
    cyc();
    idle_in();

    // load: mask forced to 0, same-cycle completion
    ls_valid = 1; ls_wen = 0; ls_wmask = 8'hFF;
    cyc();
    idle_in();
    mem_ready = 1; mem_rvalid = 1;
    mem_rdata = 64'h1234_5678_9ABC_DEF0;
    #1 chk("ld_wmask", mem_wmask, 0);
    chk("ld_same_cycle", ls_rvalid, 1);
    cyc();
    idle_in();
    #1 chk("ld_busy_next", busy, 0);
    cyc();

    // reset during RESP
    if_valid = 1;
    cyc();
    if_valid = 0; mem_ready = 1;
    cyc();
    mem_ready = 0; if_valid = 1; ls_valid = 1;
    #2 rst = 0;
    m_reset();
    #1 chk("rst_mid_outs", outs_or(), 0);
    cyc();
    rst = 1; idle_in(); mem_rvalid = 1;
    #1 chk("late_if_rvalid", if_rvalid, 0);
    chk("late_ls_rvalid", ls_rvalid, 0);
    cyc();
    idle_in();
    cyc();

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if_valid   = ($urandom % 3) != 0;
      ls_valid   = $urandom % 2;
      if_addr    = {$urandom, $urandom};
      ls_addr    = {$urandom, $urandom};
      ls_wen     = $urandom % 2;
      ls_wdata   = {$urandom, $urandom};
      ls_wmask   = 8'($urandom);
      mem_ready  = $urandom % 2;
      mem_rvalid = ($urandom % 3) == 0;
      mem_rdata  = {$urandom, $urandom};
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
